// File: rtl/fdivsqrt_result_buf_if.sv
// fdivsqrt_result_buf_if: writeback-side valid/ready result channel of the divide/sqrt result buffer.
interface fdivsqrt_result_buf_if #(parameter int FLEN = 64);
  logic            ResValidM, ResReadyM, IntDivM;
  logic [FLEN-1:0] ResM;
  logic [4:0]      FlagsM, RdM;
  modport master(output ResValidM, ResM, FlagsM, IntDivM, RdM, input ResReadyM);
  modport slave(input ResValidM, ResM, FlagsM, IntDivM, RdM, output ResReadyM);
endinterface

// File: rtl/fdivsqrt_result_buf.sv
// fdivsqrt_result_buf: result FIFO with start credits between divide/sqrt sequencer and writeback.
// Define FDIVSQRT_RESBUF_BYPASS_EN to forward a result straight through when the buffer is empty.
module fdivsqrt_result_buf #(
  parameter int FLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 FlushE,
  input  logic                 StartE,
  input  logic                 DoneE,
  input  logic [FLEN-1:0]      ResultE,
  input  logic [4:0]           FlagsE,
  input  logic                 IntDivE,
  input  logic [4:0]           RdE,
  output logic                 CanStartE,
  output logic [CNTW-1:0]      CountM,
  output logic                 OverflowM,
  fdivsqrt_result_buf_if.master wb
);
  typedef enum logic {EMPTY, NONEMPTY} head_t;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNTW-1:0] DEP = CNTW'(DEPTH);
  logic [FLEN-1:0] mem_res [DEPTH];
  logic [4:0]      mem_flg [DEPTH];
  logic [4:0]      mem_rd  [DEPTH];
  logic            mem_int [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [CNTW-1:0] cnt, cred, cnt_n, cred_n;
  logic [PW-1:0]   wptr, rptr, shw, rptr_n;
  logic            ovf, byp, pop, push, wr, rd;
  head_t           head;
  // shw tracks the slot on display so outputs hold their last value once drained
  always_comb begin
    head = (cnt == '0) ? EMPTY : NONEMPTY;
`ifdef FDIVSQRT_RESBUF_BYPASS_EN
    byp = (head == EMPTY) & DoneE & ~FlushE;
`else
    byp = 1'b0;
`endif
    wb.ResValidM = (head == NONEMPTY) | byp;
    wb.ResM      = byp ? ResultE : mem_res[shw];
    wb.FlagsM    = byp ? FlagsE  : mem_flg[shw];
    wb.IntDivM   = byp ? IntDivE : mem_int[shw];
    wb.RdM       = byp ? RdE     : mem_rd[shw];
    pop    = wb.ResValidM & wb.ResReadyM;
    push   = DoneE & ((cnt < DEP) | pop);
    wr     = push & ~(byp & wb.ResReadyM);
    rd     = pop & (head == NONEMPTY);
    cnt_n  = cnt + CNTW'(wr) - CNTW'(rd);
    rptr_n = rptr + PW'(rd);
    cred_n = (StartE & ~pop) ? ((cred == '0) ? cred : cred - CNTW'(1)) :
             (pop & ~StartE) ? cred + CNTW'(1) : cred;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      cred <= DEP;
      wptr <= '0;
      rptr <= '0;
      shw  <= '0;
      vld  <= '0;
      ovf  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_res[i] <= '0;
        mem_flg[i] <= '0;
        mem_rd[i]  <= '0;
        mem_int[i] <= 1'b0;
      end
    end else if (FlushE) begin
      cnt  <= '0;
      cred <= DEP;
      wptr <= '0;
      rptr <= '0;
      vld  <= '0;
    end else begin
      ovf  <= ovf | (DoneE & ~push) | (StartE & (cred == '0));
      cnt  <= cnt_n;
      cred <= cred_n;
      wptr <= wptr + PW'(wr);
      rptr <= rptr_n;
      shw  <= (cnt_n != '0) ? rptr_n : shw;
      vld  <= (vld & ~(DEPTH'(rd) << rptr)) | (DEPTH'(wr) << wptr);
      if (wr) begin
        mem_res[wptr] <= ResultE;
        mem_flg[wptr] <= FlagsE;
        mem_rd[wptr]  <= RdE;
        mem_int[wptr] <= IntDivE;
      end
    end
  end
  assign CanStartE = cred != '0;
  assign CountM    = cnt;
  assign OverflowM = ovf;
  assert property (@(posedge clk) disable iff (!reset)
    (cnt <= DEP) && (cred <= DEP) && (vld[rptr] == (cnt != '0)));
endmodule

// File: tb/tb_fdivsqrt_result_buf.sv
// tb_fdivsqrt_result_buf: directed self-checking bench for the divide/sqrt result buffer.
module tb_fdivsqrt_result_buf;
  logic        clk = 0, reset = 0, FlushE = 0, StartE = 0, DoneE = 0, IntDivE = 0;
  logic [63:0] ResultE = '0;
  logic [4:0]  FlagsE = '0, RdE = '0;
  logic        CanStartE, OverflowM;
  logic [1:0]  CountM;
  int          n_vec = 0, n_err = 0;
  fdivsqrt_result_buf_if #(.FLEN(64)) wb();
  fdivsqrt_result_buf #(.FLEN(64), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .FlushE(FlushE), .StartE(StartE), .DoneE(DoneE),
    .ResultE(ResultE), .FlagsE(FlagsE), .IntDivE(IntDivE), .RdE(RdE),
    .CanStartE(CanStartE), .CountM(CountM), .OverflowM(OverflowM), .wb(wb)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic done_rd(input logic [4:0] rd);
    DoneE = 1; RdE = rd; ResultE = {59'h0, rd}; cyc(); DoneE = 0;
  endtask
  task automatic test_reset();
    reset = 0;
    wb.ResReadyM = 0;
    repeat (3) cyc();
    n_vec++; if (CountM !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", CountM); end
    n_vec++; if (CanStartE !== 1'b1) begin n_err++; $display("FAIL reset_canstart got %b want 1", CanStartE); end
    n_vec++; if (wb.ResValidM !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", wb.ResValidM); end
    n_vec++; if (OverflowM !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", OverflowM); end
    n_vec++; if (wb.ResM !== 64'h0 || wb.RdM !== 5'd0) begin n_err++; $display("FAIL reset_data got %h/%0d want 0/0", wb.ResM, wb.RdM); end
    reset = 1;
    cyc();
    StartE = 1; cyc();
    n_vec++; if (CanStartE !== 1'b1) begin n_err++; $display("FAIL reset_credit1 got %b want 1", CanStartE); end
    cyc(); StartE = 0;
    n_vec++; if (CanStartE !== 1'b0) begin n_err++; $display("FAIL reset_credit0 got %b want 0", CanStartE); end
    FlushE = 1; cyc(); FlushE = 0;
    n_vec++; if (CanStartE !== 1'b1) begin n_err++; $display("FAIL reset_flush_credit got %b want 1", CanStartE); end
  endtask
  task automatic test_single();
    StartE = 1; cyc(); StartE = 0;
    DoneE = 1; ResultE = 64'h3FF0_0000_0000_0000; FlagsE = 5'b00001; RdE = 5'd5; IntDivE = 0;
    cyc(); DoneE = 0;
    n_vec++; if (wb.ResValidM !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", wb.ResValidM); end
    n_vec++; if (wb.ResM !== 64'h3FF0_0000_0000_0000) begin n_err++; $display("FAIL single_res got %h want 3ff0000000000000", wb.ResM); end
    n_vec++; if (wb.FlagsM !== 5'b00001 || wb.RdM !== 5'd5 || wb.IntDivM !== 1'b0) begin n_err++; $display("FAIL single_fields got %b/%0d/%b want 00001/5/0", wb.FlagsM, wb.RdM, wb.IntDivM); end
    n_vec++; if (CountM !== 2'd1) begin n_err++; $display("FAIL single_count got %0d want 1", CountM); end
    wb.ResReadyM = 1; cyc(); wb.ResReadyM = 0;
    n_vec++; if (wb.ResValidM !== 1'b0 || CountM !== 2'd0) begin n_err++; $display("FAIL single_pop got %b/%0d want 0/0", wb.ResValidM, CountM); end
    n_vec++; if (CanStartE !== 1'b1) begin n_err++; $display("FAIL single_canstart got %b want 1", CanStartE); end
    n_vec++; if (wb.ResM !== 64'h3FF0_0000_0000_0000) begin n_err++; $display("FAIL single_hold got %h want 3ff0000000000000", wb.ResM); end
  endtask
  task automatic test_backpressure();
    StartE = 1; cyc();
    DoneE = 1; RdE = 5'd3; cyc();
    StartE = 0; RdE = 5'd7; cyc(); DoneE = 0;
    n_vec++; if (CountM !== 2'd2) begin n_err++; $display("FAIL bp_count got %0d want 2", CountM); end
    n_vec++; if (CanStartE !== 1'b0) begin n_err++; $display("FAIL bp_canstart got %b want 0", CanStartE); end
    n_vec++; if (wb.RdM !== 5'd3 || wb.ResValidM !== 1'b1) begin n_err++; $display("FAIL bp_head got %0d/%b want 3/1", wb.RdM, wb.ResValidM); end
    wb.ResReadyM = 1; cyc(); wb.ResReadyM = 0;
    n_vec++; if (wb.RdM !== 5'd7 || CountM !== 2'd1) begin n_err++; $display("FAIL bp_pop1 got %0d/%0d want 7/1", wb.RdM, CountM); end
    n_vec++; if (CanStartE !== 1'b1) begin n_err++; $display("FAIL bp_credit got %b want 1", CanStartE); end
    wb.ResReadyM = 1; cyc(); wb.ResReadyM = 0;
    n_vec++; if (CountM !== 2'd0 || wb.ResValidM !== 1'b0) begin n_err++; $display("FAIL bp_pop2 got %0d/%b want 0/0", CountM, wb.ResValidM); end
  endtask
  task automatic test_full_pushpop();
    StartE = 1; cyc(); cyc(); StartE = 0;
    done_rd(5'd1); done_rd(5'd2);
    n_vec++; if (CountM !== 2'd2 || wb.RdM !== 5'd1) begin n_err++; $display("FAIL full_fill got %0d/%0d want 2/1", CountM, wb.RdM); end
    wb.ResReadyM = 1; done_rd(5'd3); wb.ResReadyM = 0;
    n_vec++; if (CountM !== 2'd2) begin n_err++; $display("FAIL full_pp_count got %0d want 2", CountM); end
    n_vec++; if (wb.RdM !== 5'd2) begin n_err++; $display("FAIL full_pp_head got %0d want 2", wb.RdM); end
    n_vec++; if (OverflowM !== 1'b0) begin n_err++; $display("FAIL full_pp_ovf got %b want 0", OverflowM); end
    wb.ResReadyM = 1; cyc(); wb.ResReadyM = 0;
    n_vec++; if (wb.RdM !== 5'd3 || wb.ResM !== 64'd3 || CountM !== 2'd1) begin n_err++; $display("FAIL full_order got %0d/%h/%0d want 3/3/1", wb.RdM, wb.ResM, CountM); end
    FlushE = 1; cyc(); FlushE = 0;
    n_vec++; if (CountM !== 2'd0 || CanStartE !== 1'b1) begin n_err++; $display("FAIL full_flush got %0d/%b want 0/1", CountM, CanStartE); end
  endtask
  task automatic test_overflow();
    StartE = 1; cyc(); cyc(); StartE = 0;
    done_rd(5'd4); done_rd(5'd5);
    done_rd(5'd6);
    n_vec++; if (OverflowM !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", OverflowM); end
    n_vec++; if (CountM !== 2'd2 || wb.RdM !== 5'd4) begin n_err++; $display("FAIL ovf_keep got %0d/%0d want 2/4", CountM, wb.RdM); end
    wb.ResReadyM = 1; cyc();
    n_vec++; if (wb.RdM !== 5'd5) begin n_err++; $display("FAIL ovf_pop got %0d want 5", wb.RdM); end
    cyc(); wb.ResReadyM = 0;
    n_vec++; if (CountM !== 2'd0 || wb.ResValidM !== 1'b0 || OverflowM !== 1'b1) begin n_err++; $display("FAIL ovf_drain got %0d/%b/%b want 0/0/1", CountM, wb.ResValidM, OverflowM); end
  endtask
  task automatic test_flush();
    StartE = 1; cyc(); cyc(); StartE = 0;
    done_rd(5'd8);
    n_vec++; if (CountM !== 2'd1 || CanStartE !== 1'b0) begin n_err++; $display("FAIL flush_pre got %0d/%b want 1/0", CountM, CanStartE); end
    FlushE = 1; done_rd(5'd9); FlushE = 0;
    n_vec++; if (CountM !== 2'd0 || wb.ResValidM !== 1'b0) begin n_err++; $display("FAIL flush_clear got %0d/%b want 0/0", CountM, wb.ResValidM); end
    n_vec++; if (CanStartE !== 1'b1 || OverflowM !== 1'b1) begin n_err++; $display("FAIL flush_credit_ovf got %b/%b want 1/1", CanStartE, OverflowM); end
    StartE = 1; cyc();
    n_vec++; if (CanStartE !== 1'b1) begin n_err++; $display("FAIL flush_start1 got %b want 1", CanStartE); end
    cyc(); StartE = 0;
    n_vec++; if (CanStartE !== 1'b0) begin n_err++; $display("FAIL flush_start2 got %b want 0", CanStartE); end
    FlushE = 1; cyc(); FlushE = 0;
  endtask
  task automatic test_empty_done();
    StartE = 1; cyc(); StartE = 0;
`ifdef FDIVSQRT_RESBUF_BYPASS_EN
    DoneE = 1; RdE = 5'd10; ResultE = 64'hC000_0000_0000_0001; wb.ResReadyM = 1;
    #1;
    n_vec++; if (wb.ResValidM !== 1'b1 || wb.RdM !== 5'd10 || wb.ResM !== 64'hC000_0000_0000_0001) begin n_err++; $display("FAIL byp_comb got %b/%0d/%h want 1/10/c000000000000001", wb.ResValidM, wb.RdM, wb.ResM); end
    cyc(); DoneE = 0; wb.ResReadyM = 0;
    n_vec++; if (CountM !== 2'd0 || wb.ResValidM !== 1'b0) begin n_err++; $display("FAIL byp_consumed got %0d/%b want 0/0", CountM, wb.ResValidM); end
    StartE = 1; cyc(); cyc(); StartE = 0;
    n_vec++; if (CanStartE !== 1'b0) begin n_err++; $display("FAIL byp_credit got %b want 0", CanStartE); end
`else
    DoneE = 1; RdE = 5'd10; ResultE = 64'hC000_0000_0000_0001; wb.ResReadyM = 1;
    #1;
    n_vec++; if (wb.ResValidM !== 1'b0) begin n_err++; $display("FAIL lat_comb got %b want 0", wb.ResValidM); end
    cyc(); DoneE = 0;
    n_vec++; if (wb.ResValidM !== 1'b1 || wb.RdM !== 5'd10 || CountM !== 2'd1) begin n_err++; $display("FAIL lat_next got %b/%0d/%0d want 1/10/1", wb.ResValidM, wb.RdM, CountM); end
    cyc(); wb.ResReadyM = 0;
    n_vec++; if (CountM !== 2'd0 || CanStartE !== 1'b1) begin n_err++; $display("FAIL lat_pop got %0d/%b want 0/1", CountM, CanStartE); end
`endif
  endtask
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full_pushpop();
    test_overflow();
    test_flush();
    test_empty_done();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fdivsqrt_result_buf.md
Name: fdivsqrt_result_buf

Overview:
- Downstream companion to the divide/square-root sequencer. Captures each completed result (value, flags, destination tag) on the done pulse into a small FIFO.
- Presents results to the M/W writeback path over a valid/ready handshake.
- Maintains a credit counter that gates new divide starts, so a started operation always has a slot waiting when it finishes.

Parameters:
- FLEN, 64, result data width in bits.
- DEPTH, 2, FIFO entries; power of two, >= 2.
- CNTW, $clog2(DEPTH+1), width of the occupancy and credit counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- FlushE  in  1  pipeline flush; clears buffer and credits
- StartE  in  1  divide start accepted this cycle (IFDivStartE from sequencer); consumes one credit
- DoneE  in  1  sequencer done pulse; push request
- ResultE  in  FLEN  result value
- FlagsE  in  5  IEEE flags NV,DZ,OF,UF,NX
- IntDivE  in  1  result is integer division
- RdE  in  5  destination register tag
- CanStartE  out  1  credit available; ANDed into start qualification upstream
- ResValidM  out  1  head entry valid
- ResReadyM  in  1  writeback consumes head this cycle
- ResM  out  FLEN  head result
- FlagsM  out  5  head flags
- IntDivM  out  1  head integer flag
- RdM  out  5  head destination tag
- CountM  out  CNTW  current occupancy
- OverflowM  out  1  sticky error: push attempted with no free entry

Behaviour:
- Reset (reset=0, asynchronous) and values held during reset:
  - all entries invalid; CountM=0; credits=DEPTH; CanStartE=1
  - ResValidM=0; ResM/FlagsM/IntDivM/RdM=0; OverflowM=0
  - read and write pointers = 0
- Pop: pop = ResValidM & ResReadyM.
- Push:
  - push = DoneE & (CountM<DEPTH | pop).
  - A push at full with a same-cycle pop is legal: occupancy stays at DEPTH.
  - DoneE with no free slot and no pop → data dropped; OverflowM set; OverflowM clears only on reset.
- Pointers: wrap modulo DEPTH.
- CountM: next = CountM + push - pop.
- Credits:
  - next = credits - StartE + pop.
  - CanStartE = (credits != 0).
  - StartE while credits==0 → credits saturate at 0 and OverflowM is set.
  - Simultaneous StartE and pop → credits unchanged.
- Ordering: strict FIFO. The head is always the oldest captured result.
- Latency: registered path. Push in cycle N → ResValidM=1 in cycle N+1 with that entry's data.
- Outputs: ResM/FlagsM/IntDivM/RdM show the head entry whenever ResValidM=1, and are held stable until popped. When ResValidM=0 they hold their last value.
- FlushE (synchronous, highest priority over push, pop and StartE):
  - next cycle: CountM=0, credits=DEPTH, ResValidM=0, pointers=0
  - OverflowM is not cleared
  - the sequencer's in-flight operation is killed by the same flush
- Invariants (for assertions):
  - credits + CountM + in-flight ops == DEPTH, where in-flight = StartE accepted with no DoneE yet
  - CountM <= DEPTH
- State per entry: valid, data, flags, IntDiv, Rd. No other FSM. The head-valid logic is a two-state (EMPTY/NONEMPTY) view derived from CountM.

Optional Feature:
- Macro: FDIVSQRT_RESBUF_BYPASS_EN.
- Defined:
  - When CountM==0 and DoneE=1, the incoming fields drive ResM/FlagsM/IntDivM/RdM combinationally, and ResValidM=1 in the same cycle.
  - If ResReadyM=1 in that cycle, the entry is consumed without being written. CountM stays 0 and the credit is returned.
  - Otherwise the entry is written as a normal push.
- Not defined: pure registered path, one-cycle latency, no combinational DoneE→ResValidM path.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → CountM=0, CanStartE=1, ResValidM=0, OverflowM=0; credits observed as 2 via two StartE pulses before CanStartE=0.
- Single op: StartE, then DoneE with ResultE=64'h3FF0_0000_0000_0000, FlagsE=5'b00001, RdE=5 → ResValidM=1 next cycle with those values; ResReadyM=1 → ResValidM=0, CanStartE=1.
- Back-pressure: ResReadyM=0, two StartE/DoneE pairs (Rd 3 then Rd 7) → CountM=2, CanStartE=0, RdM=3; pop once → RdM=7; pop again → CountM=0.
- Full with simultaneous push/pop: CountM=2, DoneE and ResReadyM=1 in the same cycle → CountM stays 2, order preserved, OverflowM=0.
- Overflow: CountM=2, DoneE with ResReadyM=0 → OverflowM=1, entry dropped, CountM=2; OverflowM remains 1 after later pops.
- Flush: CountM=1, one op in flight, FlushE pulse coincident with DoneE → next cycle CountM=0, ResValidM=0, CanStartE=1, two starts available; with FDIVSQRT_RESBUF_BYPASS_EN, empty buffer with DoneE and ResReadyM=1 → ResValidM=1 the same cycle and CountM remains 0.
